// File: rtl/mic_i2s_capture_if.sv
// DMA-facing read port of the microphone capture block: word select in,
// buffered word, frame-ready flag and overrun counter out.
interface mic_i2s_capture_if;
   logic [2:0]  select;
   logic [31:0] mic_data;
   logic        read_ready;
   logic [15:0] overrun_count;

   modport master (output select, input mic_data, read_ready, overrun_count);
   modport slave  (input select, output mic_data, read_ready, overrun_count);
endinterface

// File: rtl/mic_i2s_capture.sv
// Stereo I2S microphone capture: shared SCK/WS generation, per-pair
// deserialisation, one-frame output buffer read by the DMA stage.
module mic_i2s_lane (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        clr,
   input  logic        shift_l,
   input  logic        shift_r,
   input  logic        commit,
   input  logic        sd_bit,
   output logic [31:0] word
);
   // Only the upper half of each channel lands in the packed word, so each
   // shifter holds just those 16 MSBs and stops once they are captured.
   logic [15:0] left_hi;
   logic [15:0] right_hi;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         left_hi  <= '0;
         right_hi <= '0;
         word     <= '0;
      end else begin
         if (clr) begin
            left_hi  <= '0;
            right_hi <= '0;
         end else begin
            if (shift_l) left_hi  <= {left_hi[14:0], sd_bit};
            if (shift_r) right_hi <= {right_hi[14:0], sd_bit};
         end
         if (commit) word <= {left_hi, right_hi};
      end
   end
endmodule

module mic_i2s_capture #(
   parameter int NUM_MIC_PAIRS = 5,
   parameter int CLK_DIV       = 4
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     enable,
   output logic                     sck,
   output logic                     ws,
   input  logic [NUM_MIC_PAIRS-1:0] sd,
   mic_i2s_capture_if.slave         dma
);
   localparam int         DIV_W    = $clog2(CLK_DIV);
   localparam logic [2:0] SEL_LAST = 3'(NUM_MIC_PAIRS);

   logic [DIV_W-1:0] div_cnt;
   logic [5:0]       slot;
   logic [5:0]       slot_nxt;
   logic             first_frame;
   logic [2:0]       prev_select;
   logic             read_ready;
   logic [15:0]      overrun_count;
   logic             div_wrap, sck_rise, sck_fall;
   logic             shift_l, shift_r, commit, consume;
   logic [NUM_MIC_PAIRS-1:0][31:0] buf_word;
   logic [31:0]      mic_data;

   assign div_wrap = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign sck_rise = enable && div_wrap && !sck;
   assign sck_fall = enable && div_wrap && sck;
   assign slot_nxt = slot + 6'd1;

   // One-bit I2S delay: left MSB arrives in slot 1, right MSB in slot 33.
   assign shift_l = sck_rise && (slot >= 6'd1)  && (slot <= 6'd16);
   assign shift_r = sck_rise && (slot >= 6'd33) && (slot <= 6'd48);
   assign commit  = sck_rise && (slot == 6'd0) && !first_frame;
   assign consume = (dma.select == SEL_LAST) && (prev_select != SEL_LAST);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         div_cnt       <= '0;
         sck           <= 1'b0;
         ws            <= 1'b0;
         slot          <= '0;
         first_frame   <= 1'b1;
         prev_select   <= '0;
         read_ready    <= 1'b0;
         overrun_count <= '0;
      end else begin
         prev_select <= dma.select;

         if (!enable) begin
            div_cnt     <= '0;
            sck         <= 1'b0;
            ws          <= 1'b0;
            slot        <= '0;
            first_frame <= 1'b1;
         end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            if (div_wrap) sck <= ~sck;
            if (sck_fall) begin
               slot <= slot_nxt;
               ws   <= slot_nxt[5];
            end
            if (sck_rise && slot == 6'd0) first_frame <= 1'b0;
         end

         // A commit outranks a same-cycle consume: the fresh frame is unread.
         if (commit)       read_ready <= 1'b1;
         else if (consume) read_ready <= 1'b0;

         if (commit && read_ready && !consume && overrun_count != 16'hFFFF)
            overrun_count <= overrun_count + 16'd1;
      end
   end

   generate
      for (genvar p = 0; p < NUM_MIC_PAIRS; p++) begin : g_lane
         mic_i2s_lane u_lane (
            .CLK     (CLK),
            .RESET   (RESET),
            .clr     (!enable),
            .shift_l (shift_l),
            .shift_r (shift_r),
            .commit  (commit),
            .sd_bit  (sd[p]),
            .word    (buf_word[p])
         );
      end
   endgenerate

   always_comb begin
      mic_data = '0;
      for (int k = 0; k < NUM_MIC_PAIRS; k++)
         if (dma.select == 3'(k + 1)) mic_data = buf_word[k];
   end

   assign dma.mic_data      = mic_data;
   assign dma.read_ready    = read_ready;
   assign dma.overrun_count = overrun_count;
endmodule

// File: tb/tb_mic_i2s_capture.sv
// Directed walk through capture, consume, overrun and disruption cases,
// with per-frame random mic data checked against a slot-level reference.
module tb_mic_i2s_capture;
   localparam int N  = 5;
   localparam int CD = 2;
   localparam int FRAME = 128 * CD;

   logic         CLK = 1'b0;
   logic         RESET, enable;
   logic         sck, ws;
   logic [N-1:0] sd = '0;

   mic_i2s_capture_if dma ();

   mic_i2s_capture #(.NUM_MIC_PAIRS(N), .CLK_DIV(CD)) dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .enable (enable),
      .sck    (sck),
      .ws     (ws),
      .sd     (sd),
      .dma    (dma)
   );

   always #10 CLK = ~CLK;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: mics emit on SCK fall; slot 1..32 left MSB-first, 33..63 then
   // next slot 0 right MSB-first. Word = top halves of left and right.
   int          tb_slot = 0;
   bit          prev_sck = 1'b0;
   bit          first = 1'b1;
   bit          just_fell = 1'b0;
   bit          rand_mode = 1'b0;
   int          s0_count = 0;
   int          commits = 0;
   logic [31:0] cur_l   [N] = '{default: '0};
   logic [31:0] cur_r   [N] = '{default: '0};
   logic [31:0] exp_buf [N] = '{default: '0};

   function automatic logic sd_bit(input int s, input logic [31:0] l, input logic [31:0] r);
      if (s >= 1 && s <= 32) return l[32 - s];
      else if (s >= 33)      return r[64 - s];
      else                   return r[0];
   endfunction

   always @(negedge CLK) begin
      just_fell = 1'b0;
      if (RESET || !enable) begin
         tb_slot  = 0;
         first    = 1'b1;
         s0_count = 0;
         prev_sck = 1'b0;
         if (RESET) for (int i = 0; i < N; i++) exp_buf[i] = '0;
      end else begin
         if (prev_sck && !sck) begin
            tb_slot   = (tb_slot + 1) % 64;
            just_fell = (tb_slot == 0);
            check("ws_slot", 32'(ws), 32'(tb_slot >= 32));
            if (tb_slot == 1)
               for (int i = 0; i < N; i++) begin
                  cur_l[i] = rand_mode ? $urandom() : 32'hA000_0000 + i;
                  cur_r[i] = rand_mode ? $urandom() : 32'h5000_0000 + i;
               end
         end else if (!prev_sck && sck && tb_slot == 0) begin
            s0_count++;
            if (first) first = 1'b0;
            else begin
               for (int i = 0; i < N; i++) exp_buf[i] = {cur_l[i][31:16], cur_r[i][31:16]};
               commits++;
            end
         end
         prev_sck = sck;
      end
      for (int i = 0; i < N; i++) sd[i] = sd_bit(tb_slot, cur_l[i], cur_r[i]);
   end

   task automatic step();
      @(negedge CLK);
      #1;
   endtask

   // Sweeps select within one low phase and restores it, so no consume is seen.
   task automatic check_buf(input string tag);
      logic [2:0] sv;
      sv = dma.select;
      for (int k = 1; k <= N; k++) begin
         dma.select = 3'(k);
         #1;
         check($sformatf("%s_sel%0d", tag, k), dma.mic_data, exp_buf[k-1]);
      end
      dma.select = sv;
   endtask

   task automatic check_sel(input logic [2:0] sel, input logic [31:0] exp);
      logic [2:0] sv;
      sv = dma.select;
      dma.select = sel;
      #1;
      check($sformatf("sel%0d_data", sel), dma.mic_data, exp);
      dma.select = sv;
   endtask

   int t, n, c0;

   initial begin
      RESET = 1'b1; enable = 1'b0; dma.select = '0;
      repeat (3) step();
      check("rst_sck", 32'(sck), 0);
      check("rst_ws", 32'(ws), 0);
      check("rst_rr", 32'(dma.read_ready), 0);
      check("rst_ovr", 32'(dma.overrun_count), 0);
      check_buf("rst");

      // first frame: fixed pattern, SCK period, discard-then-commit
      RESET = 1'b0; enable = 1'b1;
      t = 0; while (!sck && t < 100) begin step(); t++; end
      n = 0;
      while (sck && n < 100)  begin step(); n++; end
      while (!sck && n < 100) begin step(); n++; end
      check("sck_period", 32'(n), 32'(2 * CD));
      t = 0; while (!dma.read_ready && t < 4 * FRAME) begin step(); t++; end
      check("f1_rr", 32'(dma.read_ready), 1);
      check("f1_s0_count", 32'(s0_count), 2);
      check("f1_commits", 32'(commits), 1);
      check_buf("f1");
      check_sel(3'd3, 32'hA000_5000);

      // consume on first arrival at the last pair; held select does not re-consume
      rand_mode = 1'b1;
      for (int k = 1; k <= 4; k++) begin dma.select = 3'(k); step(); end
      check("cons_pre", 32'(dma.read_ready), 1);
      dma.select = 3'd5; step();
      check("cons_clr", 32'(dma.read_ready), 0);
      repeat (10) step();
      check("cons_hold", 32'(dma.read_ready), 0);
      c0 = commits;
      t = 0; while (commits == c0 && t < 2 * FRAME) begin step(); t++; end
      check("cons_commit", 32'(dma.read_ready), 1);
      repeat (3) step();
      check("no_reclear", 32'(dma.read_ready), 1);
      check_buf("f2");

      // overrun: three commits with no consume after clearing
      dma.select = 3'd0; step();
      dma.select = 3'd5; step();
      check("ovr_clr", 32'(dma.read_ready), 0);
      dma.select = 3'd0;
      c0 = commits;
      t = 0; while (commits < c0 + 3 && t < 5 * FRAME) begin step(); t++; end
      check("ovr_count", 32'(dma.overrun_count), 2);
      check_buf("ovr");
      check_sel(3'd0, 32'h0);
      check_sel(3'd6, 32'h0);
      check_sel(3'd7, 32'h0);

      // commit and consume in the same cycle
      t = 0; while (!just_fell && t < 2 * FRAME) begin step(); t++; end
      check("cc_sync", 32'(just_fell), 1);
      repeat (CD - 1) step();
      dma.select = 3'd5;
      c0 = commits;
      step();
      check("cc_commit", 32'(commits), 32'(c0 + 1));
      check("cc_rr", 32'(dma.read_ready), 1);
      check("cc_ovr", 32'(dma.overrun_count), 2);
      step();
      check("cc_rr_next", 32'(dma.read_ready), 1);
      check_buf("cc");

      // reset at slot 40
      dma.select = 3'd0;
      t = 0; while (tb_slot != 40 && t < 2 * FRAME) begin step(); t++; end
      check("rst40_sync", 32'(tb_slot), 40);
      RESET = 1'b1;
      repeat (3) step();
      check("rst40_sck", 32'(sck), 0);
      check("rst40_ws", 32'(ws), 0);
      check("rst40_rr", 32'(dma.read_ready), 0);
      check("rst40_ovr", 32'(dma.overrun_count), 0);
      check_buf("rst40");
      RESET = 1'b0;
      t = 0; while (!dma.read_ready && t < 4 * FRAME) begin step(); t++; end
      check("rst40_rr_rise", 32'(dma.read_ready), 1);
      check("rst40_s0", 32'(s0_count), 2);
      check_buf("rst40_f");

      // enable dropped at slot 40; buffer and read_ready retained
      t = 0; while (tb_slot != 40 && t < 2 * FRAME) begin step(); t++; end
      check("dis40_sync", 32'(tb_slot), 40);
      enable = 1'b0;
      repeat (20) step();
      check("dis_sck", 32'(sck), 0);
      check("dis_ws", 32'(ws), 0);
      check("dis_rr", 32'(dma.read_ready), 1);
      check_buf("dis");
      enable = 1'b1;
      t = 0; while (dma.overrun_count == 16'd0 && t < 4 * FRAME) begin step(); t++; end
      check("en_ovr", 32'(dma.overrun_count), 1);
      check("en_s0", 32'(s0_count), 2);
      check_buf("en_f");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mic_i2s_capture.md
Name: mic_i2s_capture

Overview:
- Upstream feeder for the microphone DMA stage.
- Drives a shared I2S bit clock and word select to NUM_MIC_PAIRS stereo I2S microphone pairs, deserialises one data line per pair, and packs each stereo sample into one 32-bit word.
- Holds one complete frame (one word per pair) in an output buffer, presents the word addressed by the DMA's select lines combinationally on mic_data, and flags new frames with read_ready.

Parameters:
- NUM_MIC_PAIRS, 5, number of stereo pairs / sd lines (1..7).
- CLK_DIV, 4, CLK cycles per SCK half-period (>=2).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- enable  in  1  capture enable.
- sck  out  1  I2S bit clock to all mics.
- ws  out  1  I2S word select (0 = left, 1 = right).
- sd  in  NUM_MIC_PAIRS  serial data, bit i = pair i.
- select  in  3  word select from DMA; value k in 1..NUM_MIC_PAIRS addresses pair k-1.
- mic_data  out  32  buffered word for the selected pair.
- read_ready  out  1  unread frame available.
- overrun_count  out  16  saturating count of frames overwritten before consumption.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (CLK, RESET).
- Reset values:
  - sck=0, ws=0, read_ready=0, overrun_count=0.
  - Output buffer all zero, so mic_data=0.
  - Divider, slot counter and shift registers cleared; first_frame flag set.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while enable=1. At wrap, sck toggles.
  - enable=0: div_cnt=0, sck=0, ws=0, slot=0, first_frame=1. Buffer, read_ready and overrun_count are retained.
- Slots:
  - slot counts 0..63 and advances on each sck falling edge, wrapping 63->0.
  - ws is registered on the same falling edge: ws=1 for slots 32..63, otherwise 0.
- Sampling:
  - On each sck rising edge, the sd bits are sampled per pair. I2S one-bit delay applies.
  - Slots 1..32 shift into left[31:0], MSB first.
  - Slots 33..63 plus slot 0 of the following frame shift into right[31:0].
- Frame commit:
  - Occurs on the rising-edge sample at slot 0 (right LSB).
  - Packed word per pair = {left[31:16], right[31:16]}.
  - If first_frame=1: discard, clear first_frame, no commit.
  - Otherwise: all NUM_MIC_PAIRS words written to the buffer in one cycle, and read_ready=1 on the next cycle (registered).
  - Frame period = 128*CLK_DIV CLK cycles.
- mic_data:
  - Combinational: buffer[select-1] for select in 1..NUM_MIC_PAIRS.
  - select=0 or select>NUM_MIC_PAIRS gives 32'h0.
  - The buffer changes only on commit.
- Consumption:
  - Registered prev_select. A consume event is the cycle where select==NUM_MIC_PAIRS and prev_select!=NUM_MIC_PAIRS (rising edge into the last pair).
  - A held select does not re-consume.
  - A consume event clears read_ready next cycle.
- Overrun: a commit while read_ready=1 with no consume in the same cycle increments overrun_count (saturating at 16'hFFFF); the new frame replaces the old one.
- Simultaneous commit + consume: the commit wins. read_ready stays 1, with no overrun.
- RESET mid-frame: the partial frame is dropped; the next frame after reset is discarded (first_frame).
- enable deasserted mid-frame: the partial frame is dropped. On re-enable, the first frame is discarded.

Test Plan:
- Reset check: RESET high 3 cycles -> sck=0, ws=0, read_ready=0, mic_data=0 for select=1..5, overrun_count=0.
- Single frame, CLK_DIV=2, NUM_MIC_PAIRS=5, enable=1:
  - Stimulus: pair i drives left=32'hA000_0000+i, right=32'h5000_0000+i over two full frames.
  - Required: read_ready rises exactly once after the second slot-0 sample.
  - Required: select=1..5 gives mic_data=32'hA000_5000 for each pair.
  - Required: first frame discarded; sck period=4 CLK; ws high for slots 32..63.
- Consume handshake: after read_ready=1, step select 1,2,3,4,5 and hold 5 for 10 cycles -> read_ready clears the cycle after select first reaches 5. No re-clear after the next commit while select is still held at 5.
- Overrun: never drive select to 5 across 3 committed frames -> overrun_count=2, mic_data shows the third frame's data.
- Boundary behaviours:
  - Commit + consume in the same cycle -> read_ready stays 1, overrun_count unchanged.
  - select=0 or 6 -> mic_data=0.
- Mid-frame disruption:
  - Assert RESET at slot 40 -> all outputs return to reset values; the next full frame is discarded and the following frame commits.
  - Repeat with enable dropped at slot 40 and reasserted -> same discard-then-commit behaviour, with buffer and read_ready retained during the disable.
